mem_access_unit: RTL and testbench

Load/store unit between the multicycle control FSM and the data memory bus. It takes one load or store request per instruction and drives a req/ack word bus with byte-lane steering. Loads get sign or zero extension. Accesses that cross a word boundary are split into two bus transactions, and a watchdog faults hung transfers. The FSM holds in its memory state while `busy` is high and advances on `done`.

---
 rtl/mem_access_pkg.sv | 46 ++++
 rtl/mem_align.sv | 45 ++++
 rtl/mem_access_unit.sv | 162 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared types for the load/store unit: FSM state encoding,
// funct3 width codes and request decode helpers.
package mem_access_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUS0,
      BUS1,
      RESP
   } state_t;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   // Access size in bytes from funct3[1:0].
   function automatic logic [2:0] size_of(input logic [2:0] f3);
      logic [2:0] n;
      n = 3'd4;
      unique case (1'b1)
         (f3[1:0] == SZ_B): n = 3'd1;
         (f3[1:0] == SZ_H): n = 3'd2;
         default:           n = 3'd4;
      endcase
      return n;
   endfunction

   // Stores take only SB/SH/SW; loads add LBU/LHU.
   function automatic logic code_ok(input logic we,
                                    input logic [2:0] f3);
      logic ok;
      if (we)
         ok = !f3[2] && (f3[1:0] != 2'b11);
      else
         ok = (f3[1:0] != 2'b11) &&
              !(f3[2] && f3[1:0] == SZ_W);
      return ok;
   endfunction

   // True when the access spills past byte 3 of its word.
   function automatic logic crossing(input logic [1:0] off,
                                     input logic [2:0] f3);
      return ({1'b0, off} + size_of(f3)) > 3'd4;
   endfunction

endpackage

// File: rtl/mem_align.sv
// Lane steering for one bus beat: byte enables, shifted write
// data and assembled/extended load data.
// Ports: off, funct3, second (BUS1 beat), wdata, w0/w1 words
//        in; be, wlane, ldata out.
module mem_align
   import mem_access_pkg::*;
(
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   input  logic        second,
   input  logic [31:0] wdata,
   input  logic [31:0] w0,
   input  logic [31:0] w1,
   output logic [3:0]  be,
   output logic [31:0] wlane,
   output logic [31:0] ldata
);

   logic [3:0]  mask;
   logic [7:0]  be_sh;
   logic [63:0] wd_sh;
   logic [31:0] lo;

   always_comb begin
      unique case (size_of(funct3))
         3'd1:    mask = 4'b0001;
         3'd2:    mask = 4'b0011;
         default: mask = 4'b1111;
      endcase
      // Upper halves of the shifted values feed the second beat.
      be_sh = {4'b0000, mask} << off;
      wd_sh = {32'b0, wdata} << {off, 3'b000};
      be    = second ? be_sh[7:4] : be_sh[3:0];
      wlane = second ? wd_sh[63:32] : wd_sh[31:0];
      lo    = 32'({w1, w0} >> {off, 3'b000});
      unique case (funct3)
         3'b000:  ldata = {{24{lo[7]}}, lo[7:0]};
         3'b001:  ldata = {{16{lo[15]}}, lo[15:0]};
         3'b100:  ldata = {24'b0, lo[7:0]};
         3'b101:  ldata = {16'b0, lo[15:0]};
         default: ldata = lo;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: one request per start, req/ack word bus with
// byte-lane steering, split crossing accesses and a watchdog.
// Ports: clk, rst (async, active-low); start/we/funct3/addr/wdata
//        request; busy/done/rdata/fault status; bus_* memory bus.
// Option: MEM_SPLIT_EN enables two-beat word-crossing accesses;
//         without it crossing requests fault at issue.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic        fault,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack
);

   localparam int CW = $clog2(TIMEOUT + 1);

`ifdef MEM_SPLIT_EN
   localparam bit SPLIT = 1'b1;
`else
   localparam bit SPLIT = 1'b0;
`endif

   state_t        state, state_n;
   logic          we_q;
   logic [2:0]    f3_q;
   logic [31:0]   addr_q, wdata_q, w0_q;
   logic [31:0]   rdata_q;
   logic          fault_q;
   logic [CW-1:0] cnt;
   logic          issue_bad, tmo, accept;
   logic [3:0]    be;
   logic [31:0]   wlane, ldata, w0;

   assign accept    = (state == IDLE) && start;
   assign issue_bad = !code_ok(we, funct3) ||
                      (!SPLIT && crossing(addr[1:0], funct3));
   assign tmo       = (cnt == CW'(TIMEOUT - 1)) && !bus_ack;
   // Single-beat loads assemble straight from the bus word.
   assign w0        = (state == BUS0) ? bus_rdata : w0_q;
   assign rdata     = rdata_q;
   assign fault     = fault_q;

   mem_align u_align (
      .off    (addr_q[1:0]),
      .funct3 (f3_q),
      .second (state == BUS1),
      .wdata  (wdata_q),
      .w0     (w0),
      .w1     (bus_rdata),
      .be     (be),
      .wlane  (wlane),
      .ldata  (ldata)
   );

   always_comb begin
      state_n   = state;
      busy      = 1'b0;
      done      = 1'b0;
      bus_req   = 1'b0;
      bus_we    = 1'b0;
      bus_addr  = 32'b0;
      bus_be    = 4'b0;
      bus_wdata = 32'b0;
      unique case (state)
         IDLE: begin
            if (start)
               state_n = issue_bad ? RESP : BUS0;
         end
         BUS0: begin
            busy      = 1'b1;
            bus_req   = 1'b1;
            bus_we    = we_q;
            bus_addr  = {addr_q[31:2], 2'b00};
            bus_be    = be;
            bus_wdata = wlane;
            if (bus_ack) begin
`ifdef MEM_SPLIT_EN
               state_n = crossing(addr_q[1:0], f3_q) ? BUS1 : RESP;
`else
               state_n = RESP;
`endif
            end else if (tmo) begin
               state_n = RESP;
            end
         end
`ifdef MEM_SPLIT_EN
         BUS1: begin
            busy      = 1'b1;
            bus_req   = 1'b1;
            bus_we    = we_q;
            bus_addr  = {addr_q[31:2], 2'b00} + 32'd4;
            bus_be    = be;
            bus_wdata = wlane;
            if (bus_ack || tmo)
               state_n = RESP;
         end
`endif
         RESP: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         we_q    <= 1'b0;
         f3_q    <= 3'b0;
         addr_q  <= 32'b0;
         wdata_q <= 32'b0;
         w0_q    <= 32'b0;
         rdata_q <= 32'b0;
         fault_q <= 1'b0;
         cnt     <= '0;
      end else begin
         state <= state_n;
         if (accept) begin
            we_q    <= we;
            f3_q    <= funct3;
            addr_q  <= addr;
            wdata_q <= wdata;
            rdata_q <= 32'b0;
            fault_q <= issue_bad;
            cnt     <= '0;
         end
         if (state == BUS0 || state == BUS1) begin
            if (bus_ack) begin
               cnt <= '0;
               if (state == BUS0)
                  w0_q <= bus_rdata;
               if (state_n == RESP && !we_q)
                  rdata_q <= ldata;
            end else if (tmo) begin
               fault_q <= 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table plus
// wait-state, watchdog and mid-transfer reset sequences.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        we = 1'b0;
   logic [2:0]  funct3 = 3'b0;
   logic [31:0] addr = 32'b0;
   logic [31:0] wdata = 32'b0;
   logic        busy, done, fault;
   logic [31:0] rdata;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_be;
   logic [31:0] bus_rdata = 32'b0;
   logic        bus_ack = 1'b0;

   int tests = 0;
   int fails = 0;

   mem_access_unit #(.TIMEOUT(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .we        (we),
      .funct3    (funct3),
      .addr      (addr),
      .wdata     (wdata),
      .busy      (busy),
      .done      (done),
      .rdata     (rdata),
      .fault     (fault),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_be    (bus_be),
      .bus_wdata (bus_wdata),
      .bus_rdata (bus_rdata),
      .bus_ack   (bus_ack)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rd0;
      logic [31:0] rd1;
      int          beats;
      logic [3:0]  be0;
      logic [3:0]  be1;
      logic [31:0] wd0;
      logic [31:0] wd1;
      logic [31:0] rdata;
      logic        fault;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(
      input logic we_i, input logic [2:0] f3, input logic [31:0] a,
      input logic [31:0] wd, input logic [31:0] r0,
      input logic [31:0] r1, input int beats, input logic [3:0] b0,
      input logic [3:0] b1, input logic [31:0] w0,
      input logic [31:0] w1, input logic [31:0] rd,
      input logic flt, input int lat);
      vec_t v;
      v.we = we_i; v.f3 = f3; v.addr = a; v.wdata = wd;
      v.rd0 = r0; v.rd1 = r1; v.beats = beats;
      v.be0 = b0; v.be1 = b1; v.wd0 = w0; v.wd1 = w1;
      v.rdata = rd; v.fault = flt; v.lat = lat;
      return v;
   endfunction

   task automatic run_vec(input vec_t v, input int id);
      int beat;
      bit got;
      logic [31:0] ea;
      logic [31:0] eb;
      logic [31:0] ew;
      beat = 0;
      got = 1'b0;
      @(negedge clk);
      start = 1'b1; we = v.we; funct3 = v.f3;
      addr = v.addr; wdata = v.wdata;
      for (int c = 1; c <= 20 && !got; c++) begin
         @(negedge clk);
         start = 1'b0;
         bus_ack = 1'b0;
         if (bus_req) begin
            if (beat < 2) begin
               ea = {v.addr[31:2], 2'b00} + (beat == 1 ? 32'd4 : 32'd0);
               eb = {28'b0, (beat == 1 ? v.be1 : v.be0)};
               ew = (beat == 1) ? v.wd1 : v.wd0;
               chk($sformatf("v%0d.b%0d.addr", id, beat), bus_addr, ea);
               chk($sformatf("v%0d.b%0d.be", id, beat), {28'b0, bus_be}, eb);
               chk($sformatf("v%0d.b%0d.wdata", id, beat), bus_wdata, ew);
               chk($sformatf("v%0d.b%0d.we", id, beat),
                   {31'b0, bus_we}, {31'b0, v.we});
               bus_rdata = (beat == 1) ? v.rd1 : v.rd0;
               bus_ack = 1'b1;
            end
            beat++;
         end
         if (done) begin
            got = 1'b1;
            chk($sformatf("v%0d.lat", id), c, v.lat);
            chk($sformatf("v%0d.beats", id), beat, v.beats);
            chk($sformatf("v%0d.fault", id), {31'b0, fault},
                {31'b0, v.fault});
            chk($sformatf("v%0d.rdata", id), rdata, v.rdata);
         end
      end
      if (!got)
         chk($sformatf("v%0d.done_seen", id), 32'd0, 32'd1);
      @(negedge clk);
      bus_ack = 1'b0;
      chk($sformatf("v%0d.idle_busy", id), {31'b0, busy}, 32'd0);
      chk($sformatf("v%0d.rdata_held", id), rdata, v.rdata);
   endtask

   initial begin
      int reqs;
      bit got;

      // we f3 addr wdata rd0 rd1 beats be0 be1 wd0 wd1 rdata fault lat
      vecs.push_back(mk(0, 3'b010, 32'h100, 0, 32'h12345678, 0,
                        1, 4'hF, 0, 0, 0, 32'h12345678, 0, 2));
      vecs.push_back(mk(0, 3'b000, 32'h103, 0, 32'h80AABBCC, 0,
                        1, 4'h8, 0, 0, 0, 32'hFFFFFF80, 0, 2));
      vecs.push_back(mk(0, 3'b100, 32'h103, 0, 32'h80AABBCC, 0,
                        1, 4'h8, 0, 0, 0, 32'h00000080, 0, 2));
      vecs.push_back(mk(0, 3'b001, 32'h101, 0, 32'h1234ABCD, 0,
                        1, 4'h6, 0, 0, 0, 32'h000034AB, 0, 2));
      vecs.push_back(mk(0, 3'b001, 32'h102, 0, 32'hF00D1234, 0,
                        1, 4'hC, 0, 0, 0, 32'hFFFFF00D, 0, 2));
      vecs.push_back(mk(0, 3'b101, 32'h102, 0, 32'hF00D1234, 0,
                        1, 4'hC, 0, 0, 0, 32'h0000F00D, 0, 2));
      vecs.push_back(mk(1, 3'b010, 32'h200, 32'hDEADBEEF, 0, 0,
                        1, 4'hF, 0, 32'hDEADBEEF, 0, 0, 0, 2));
      vecs.push_back(mk(1, 3'b000, 32'h201, 32'h000000A5, 0, 0,
                        1, 4'h2, 0, 32'h0000A500, 0, 0, 0, 2));
      vecs.push_back(mk(0, 3'b011, 32'h100, 0, 0, 0,
                        0, 0, 0, 0, 0, 0, 1, 1));
      vecs.push_back(mk(1, 3'b100, 32'h100, 0, 0, 0,
                        0, 0, 0, 0, 0, 0, 1, 1));
`ifdef MEM_SPLIT_EN
      vecs.push_back(mk(0, 3'b010, 32'h102, 0, 32'h5678AAAA,
                        32'hBBBB1234, 2, 4'hC, 4'h3, 0, 0,
                        32'h12345678, 0, 3));
      vecs.push_back(mk(1, 3'b001, 32'h103, 32'h0000BEEF, 0, 0,
                        2, 4'h8, 4'h1, 32'hEF000000, 32'h000000BE,
                        0, 0, 3));
`else
      vecs.push_back(mk(0, 3'b010, 32'h102, 0, 0, 0,
                        0, 0, 0, 0, 0, 0, 1, 1));
      vecs.push_back(mk(1, 3'b001, 32'h103, 32'h0000BEEF, 0, 0,
                        0, 0, 0, 0, 0, 0, 1, 1));
`endif

      // Reset state.
      #12;
      chk("rst.ctl", {27'b0, busy, done, fault, bus_req, bus_we}, 0);
      chk("rst.addr", bus_addr, 0);
      chk("rst.be", {28'b0, bus_be}, 0);
      chk("rst.rdata", rdata, 0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < vecs.size(); i++)
         run_vec(vecs[i], i);

      // SH with two wait cycles before ack.
      @(negedge clk);
      start = 1'b1; we = 1'b1; funct3 = 3'b001;
      addr = 32'h102; wdata = 32'h0000BEEF;
      got = 1'b0;
      for (int c = 1; c <= 20 && !got; c++) begin
         @(negedge clk);
         start = 1'b0;
         bus_ack = 1'b0;
         if (c <= 3) begin
            chk($sformatf("ws.c%0d.req", c), {31'b0, bus_req}, 1);
            chk($sformatf("ws.c%0d.be", c), {28'b0, bus_be}, 32'hC);
            chk($sformatf("ws.c%0d.wdata", c), bus_wdata, 32'hBEEF0000);
            chk($sformatf("ws.c%0d.we", c), {31'b0, bus_we}, 1);
         end
         if (c == 3)
            bus_ack = 1'b1;
         if (done) begin
            got = 1'b1;
            chk("ws.lat", c, 4);
            chk("ws.fault", {31'b0, fault}, 0);
         end
      end
      if (!got)
         chk("ws.done_seen", 0, 1);
      @(negedge clk);
      bus_ack = 1'b0;

      // Watchdog with a stray start during the wait.
      @(negedge clk);
      start = 1'b1; we = 1'b0; funct3 = 3'b010;
      addr = 32'h100; wdata = 0;
      reqs = 0;
      got = 1'b0;
      for (int c = 1; c <= 30 && !got; c++) begin
         @(negedge clk);
         start = (c == 3);
         bus_ack = 1'b0;
         if (bus_req)
            reqs++;
         if (done) begin
            got = 1'b1;
            chk("to.lat", c, 9);
            chk("to.fault", {31'b0, fault}, 1);
            chk("to.rdata", rdata, 0);
         end
      end
      start = 1'b0;
      if (!got)
         chk("to.done_seen", 0, 1);
      chk("to.req_cycles", reqs, 8);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("to.ignored%0d", c), {30'b0, busy, bus_req}, 0);
      end

      // Reset asserted while BUS0 waits for ack.
      @(negedge clk);
      start = 1'b1; we = 1'b1; funct3 = 3'b010;
      addr = 32'h300; wdata = 32'hCAFEF00D;
      @(negedge clk);
      start = 1'b0;
      chk("mr.req_before", {31'b0, bus_req}, 1);
      #2 rst = 1'b0;
      #1;
      chk("mr.ctl", {27'b0, busy, done, fault, bus_req, bus_we}, 0);
      chk("mr.addr", bus_addr, 0);
      chk("mr.wdata", bus_wdata, 0);
      chk("mr.be", {28'b0, bus_be}, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      run_vec(vecs[0], 100);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
